// File: rtl/seg7_pio_pkg.sv
// Shared constants for the seven-segment PIO array: register offsets,
// CTRL bit positions, CTRL reset value and the hex-to-segment table.
// Optional hex decode is enabled by defining SEG7_PIO_HEX_DECODE_EN.
package seg7_pio_pkg;

    localparam int DIGIT_BASE = 0;
    localparam int MASK_OFS   = 8;
    localparam int CTRL_OFS   = 9;
    localparam int STATUS_OFS = 10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_INV_BIT    = 1;
    localparam int CTRL_DECODE_BIT = 2;
    localparam int CTRL_SYNC_BIT   = 3;

    localparam logic [3:0] CTRL_RESET = 4'h1;

    // Active-high segments, bit0 = a .. bit6 = g; b and d are lowercase.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic en;
        logic inv;
        logic decode;
    } ctrl_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex nibble to segment pattern lookup.
// Only instantiated when SEG7_PIO_HEX_DECODE_EN is defined.
module seg7_hex_decode
    import seg7_pio_pkg::*;
#(
    parameter int SEG_W = 7
) (
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    // Copy table bits into the output, padding or trimming to SEG_W.
    always_comb begin
        seg_o = '0;
        for (int b = 0; b < SEG_W && b < 7; b++) begin
            seg_o[b] = HEX_SEG_TABLE[hex_i][b];
        end
    end

endmodule

// File: rtl/seg7_pio_array.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with global
// enable, polarity inversion, a prescaled blink engine and a registered
// output stage. Define SEG7_PIO_HEX_DECODE_EN to add CTRL.DECODE.
module seg7_pio_array
    import seg7_pio_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int BLINK_DIV  = 25000000,
    parameter int ADDR_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_DIGITS*SEG_W-1:0] out_port,
    output logic                        blink_phase
);

    localparam int PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

    logic [SEG_W-1:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]       blinkMask_q;
    ctrl_t                       ctrl_q;
    logic [PRESC_W-1:0]          prescale_q;
    logic                        phase_q;
    logic [NUM_DIGITS*SEG_W-1:0] out_d;
    logic [NUM_DIGITS*SEG_W-1:0] out_q;

    logic                        writeEn;
    logic                        ctrlHit;
    logic                        blinkSync;
    logic [SEG_W-1:0]            writeSeg;
    logic                        unusedWriteBits;

    assign writeEn         = chipselect && !write_n;
    assign ctrlHit         = writeEn && (address == ADDR_W'(CTRL_OFS));
    assign blinkSync       = ctrlHit && writedata[CTRL_SYNC_BIT];
    assign unusedWriteBits = &{1'b0, writedata};

`ifdef SEG7_PIO_HEX_DECODE_EN
    logic [SEG_W-1:0] decodedSeg;

    seg7_hex_decode #(.SEG_W(SEG_W)) u_hexDecode (
        .hex_i (writedata[3:0]),
        .seg_o (decodedSeg)
    );

    assign writeSeg = ctrl_q.decode ? decodedSeg : writedata[SEG_W-1:0];
`else
    assign writeSeg = writedata[SEG_W-1:0];
`endif

    // Register bank: digit patterns, blink mask and control bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            blinkMask_q   <= '0;
            ctrl_q.en     <= CTRL_RESET[CTRL_EN_BIT];
            ctrl_q.inv    <= CTRL_RESET[CTRL_INV_BIT];
            ctrl_q.decode <= CTRL_RESET[CTRL_DECODE_BIT];
        end else if (writeEn) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == ADDR_W'(DIGIT_BASE + i)) begin
                    digit_q[i] <= writeSeg;
                end
            end
            if (address == ADDR_W'(MASK_OFS)) begin
                blinkMask_q <= writedata[NUM_DIGITS-1:0];
            end
            if (ctrlHit) begin
                ctrl_q.en  <= writedata[CTRL_EN_BIT];
                ctrl_q.inv <= writedata[CTRL_INV_BIT];
`ifdef SEG7_PIO_HEX_DECODE_EN
                ctrl_q.decode <= writedata[CTRL_DECODE_BIT];
`endif
            end
        end
    end

    // Blink prescaler; a BLINK_SYNC write restarts it ahead of any wrap.
    always_ff @(posedge clk) begin
        if (reset || blinkSync) begin
            prescale_q <= '0;
            phase_q    <= 1'b0;
        end else if (prescale_q == PRESC_LAST) begin
            prescale_q <= '0;
            phase_q    <= !phase_q;
        end else begin
            prescale_q <= prescale_q + 1'b1;
        end
    end

    // Next segment image: blank disabled or blinked-off digits, then invert.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!ctrl_q.en || (blinkMask_q[i] && phase_q)) begin
                out_d[i*SEG_W +: SEG_W] = ctrl_q.inv ? '1 : '0;
            end else begin
                out_d[i*SEG_W +: SEG_W] = ctrl_q.inv ? ~digit_q[i] : digit_q[i];
            end
        end
    end

    // Registered output stage toward the display pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Zero-wait-state read mux; unmapped addresses and bits read zero.
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == ADDR_W'(DIGIT_BASE + i)) begin
                readdata[SEG_W-1:0] = digit_q[i];
            end
        end
        if (address == ADDR_W'(MASK_OFS)) begin
            readdata[NUM_DIGITS-1:0] = blinkMask_q;
        end
        if (address == ADDR_W'(CTRL_OFS)) begin
            readdata[CTRL_EN_BIT]     = ctrl_q.en;
            readdata[CTRL_INV_BIT]    = ctrl_q.inv;
            readdata[CTRL_DECODE_BIT] = ctrl_q.decode;
        end
        if (address == ADDR_W'(STATUS_OFS)) begin
            readdata[0] = phase_q;
        end
    end

    assign out_port    = out_q;
    assign blink_phase = phase_q;

endmodule
